// File: rtl/sseg_scan_controller_pkg.sv
// Shared constants, buffer type and small helpers for the seven-segment scan controller.
// All segment and anode encodings here are active-low.
package sseg_scan_controller_pkg;

    localparam int         NUM_DIGITS = 4;
    localparam int         IDX_W      = 2;
    localparam logic [7:0] SSEG_OFF   = 8'hFF;
    localparam logic [3:0] AN_OFF     = 4'b1111;
    localparam logic [6:0] SEG_BLANK  = 7'b1111111;

    typedef logic [IDX_W-1:0] digit_idx_t;

    // One display image: what a whole frame shows.
    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  dp_mask;
        logic        lzb;
    } disp_buf_t;

    localparam disp_buf_t BUF_CLEAR = '0;

    // Digit k (k >= 1) is blanked when leading-zero blanking is on and it,
    // together with every more significant digit, is zero.
    function automatic logic digit_blanked(input disp_buf_t buf_in, input digit_idx_t idx);
        logic blank;
        blank = 1'b0;
        if (buf_in.lzb && (idx != '0)) begin
            blank = 1'b1;
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if ((k >= int'(idx)) && (buf_in.value[4*k +: 4] != 4'h0)) begin
                    blank = 1'b0;
                end
            end
        end
        return blank;
    endfunction

    function automatic logic [3:0] anode_for(input digit_idx_t idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/sseg_scan_controller_decoder.sv
// Hex nibble to active-low seven-segment pattern {A,B,C,D,E,F,G,DP}.
// Purely combinational; the caller registers the result.
module Hex_to_7seg_Decoder
    import sseg_scan_controller_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] sseg
);

    logic [6:0] seg7;

    always_comb begin
        seg7 = SEG_BLANK;
        case (nibble)
            4'h0: seg7 = 7'b0000001;
            4'h1: seg7 = 7'b1001111;
            4'h2: seg7 = 7'b0010010;
            4'h3: seg7 = 7'b0000110;
            4'h4: seg7 = 7'b1001100;
            4'h5: seg7 = 7'b0100100;
            4'h6: seg7 = 7'b0100000;
            4'h7: seg7 = 7'b0001111;
            4'h8: seg7 = 7'b0000000;
            4'h9: seg7 = 7'b0000100;
            4'hA: seg7 = 7'b0001000;
            4'hB: seg7 = 7'b1100000;
            4'hC: seg7 = 7'b0110001;
            4'hD: seg7 = 7'b1000010;
            4'hE: seg7 = 7'b0110000;
            4'hF: seg7 = 7'b0111000;
            default: seg7 = SEG_BLANK;
        endcase
        sseg = {seg7, ~dp};
    end

endmodule

// File: rtl/sseg_scan_controller.sv
// Four-digit common-anode scan controller with double-buffered display data
// that is only committed at frame boundaries (end of the digit-3 slot).
module sseg_scan_controller
    import sseg_scan_controller_pkg::*;
#(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Enable,
    input  logic        Load,
    input  logic [15:0] Value,
    input  logic [3:0]  DPMask,
    input  logic        LZB,
    output logic        Pending,
    output logic        FrameTick,
    output logic [3:0]  An,
    output logic [7:0]  SSeg
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

    logic [CNT_W-1:0] cnt;
    digit_idx_t       idx;
    disp_buf_t        active_buf;
    disp_buf_t        pending_buf;
    disp_buf_t        load_buf;

    logic             terminal;
    logic             boundary;
    logic [3:0]       nibble;
    logic             dp;
    logic [7:0]       dec_seg;
    logic             blank;
    logic [7:0]       seg_next;
    logic [3:0]       an_next;

    assign load_buf = '{value: Value, dp_mask: DPMask, lzb: LZB};
    assign terminal = (cnt == CNT_LAST);
    assign boundary = Enable && terminal && (idx == digit_idx_t'(NUM_DIGITS - 1));

    // Slot counter and digit index freeze whenever scanning is disabled.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt <= '0;
            idx <= '0;
        end else if (Enable) begin
            if (terminal) begin
                cnt <= '0;
                idx <= idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // A load landing on the boundary edge goes straight to the active image.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            active_buf  <= BUF_CLEAR;
            pending_buf <= BUF_CLEAR;
            Pending     <= 1'b0;
            FrameTick   <= 1'b0;
        end else begin
            FrameTick <= boundary;
            if (boundary) begin
                if (Load) begin
                    active_buf <= load_buf;
                end else if (Pending) begin
                    active_buf <= pending_buf;
                end
                Pending <= 1'b0;
            end else if (Load) begin
                pending_buf <= load_buf;
                Pending     <= 1'b1;
            end
        end
    end

    assign nibble = active_buf.value[{idx, 2'b00} +: 4];
    assign dp     = active_buf.dp_mask[idx];
    assign blank  = digit_blanked(active_buf, idx);

    Hex_to_7seg_Decoder u_decoder (
        .nibble (nibble),
        .dp     (dp),
        .sseg   (dec_seg)
    );

    always_comb begin
        seg_next = blank ? {SEG_BLANK, ~dp} : dec_seg;
        an_next  = (cnt < CNT_BLANK) ? AN_OFF : anode_for(idx);
    end

    // Anodes and segments share one register stage so they always switch together.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            An   <= AN_OFF;
            SSeg <= SSEG_OFF;
        end else if (Enable) begin
            An   <= an_next;
            SSeg <= seg_next;
        end else begin
            An   <= AN_OFF;
            SSeg <= SSEG_OFF;
        end
    end

endmodule

// File: doc/sseg_scan_controller.md
# sseg_scan_controller

Time-multiplexed scan controller for a 4-digit common-anode seven-segment display. It drives one shared segment bus through a single `Hex_to_7seg_Decoder` instance and cycles the digit enables. Display data is double-buffered and committed only at frame boundaries, so a frame never mixes old and new digits. It sits between the value-producing logic (counters, ALU results) and the board's display pins.

## Interface
- `REFRESH_DIV`, default 50000: clock cycles per digit slot; legal range ≥ 4.
- `BLANK_CYCLES`, default 500: cycles at the start of each slot with all anodes off (anti-ghosting); legal range < `REFRESH_DIV`.
- `Clk`  in  1  system clock; all state changes on its rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `Enable`  in  1  1 = scanning; 0 = display dark, scan frozen.
- `Load`  in  1  one-cycle strobe; captures `Value`, `DPMask`, `LZB` into the pending buffer.
- `Value`  in  16  four hex nibbles; [3:0] is digit 0 (rightmost).
- `DPMask`  in  4  per-digit decimal point; 1 = lit.
- `LZB`  in  1  leading-zero blanking enable.
- `Pending`  out  1  a loaded value is waiting for the next frame boundary.
- `FrameTick`  out  1  one-cycle pulse on the cycle the active buffer is (re)committed.
- `An`  out  4  digit enables, active-low; one-hot-low or all-ones.
- `SSeg`  out  8  {A,B,C,D,E,F,G,DP}, active-low (0 = segment on).

## Operation
- Slot counter `Cnt` counts 0..`REFRESH_DIV`-1 while `Enable`=1. At terminal count it wraps to 0 and digit index `Idx` advances 0→1→2→3→0.
- Frame boundary: the terminal-count cycle with `Idx`=3. On that edge the active buffer loads from pending if `Pending`=1, `Pending` clears, and `FrameTick` pulses. `FrameTick` pulses at every boundary, even with no pending data.
- `Load`:
  - Writes the pending buffer and sets `Pending`.
  - A `Load` while `Pending`=1 overwrites the pending buffer; latest wins.
  - A `Load` on the boundary cycle bypasses pending: it commits straight to active, and `Pending` ends at 0.
- Per-slot output:
  - Digit nibble = active `Value[4*Idx+3:4*Idx]`, DP = active `DPMask[Idx]`; both feed the decoder.
  - Leading-zero blanking: when active `LZB`=1, digit k (k≥1) is blanked if it and all higher digits are 0. Digit 0 is never blanked.
  - A blanked digit drives `SSeg` = {7'b1111111, ~DP}.
- Anodes: during `Cnt` < `BLANK_CYCLES`, `An`=4'b1111. Otherwise `An` = ~(1<<`Idx`).
- `Enable`=0: next edge forces `An`=4'b1111 and `SSeg`=8'hFF; `Cnt` and `Idx` hold. `Load` is still accepted. No commit occurs, because there is no terminal count.
- `Enable` 0→1: resumes from the held `Cnt`/`Idx`.

## Timing
- Reset values: `An`=4'b1111, `SSeg`=8'hFF, `Pending`=0, `FrameTick`=0, `Cnt`=0, `Idx`=0, active and pending buffers all-zero.
- Output timing:
  - `An` and `SSeg` are registered and reflect the `Cnt`/`Idx` state of the previous cycle (1-cycle latency).
  - They change on the same edge, so the segment bus never shows another digit's data while its anode is enabled.
- `Pending` rises the edge after `Load`. `FrameTick` is high exactly one cycle, coincident with the first cycle the new active data is visible in state.
- Frame period = 4×`REFRESH_DIV` cycles. Worst-case load-to-display latency = 4×`REFRESH_DIV` + 1 cycles.
- `Reset` asserted mid-frame clears all state immediately (asynchronous) and discards pending data. Scanning restarts at digit 0 with `Cnt`=0 on the first edge after release.

## Structure
- Shared package: digit count (4), `SSEG_OFF` = 8'hFF, `AN_OFF` = 4'b1111.
- One sub-module: `Hex_to_7seg_Decoder`, a single instance fed by the muxed nibble/DP. The blank override is applied after it, before the output register.
- Slot counter width = $clog2(`REFRESH_DIV`).

## Test plan
Bench settings: `REFRESH_DIV`=8, `BLANK_CYCLES`=2.
- Reset then `Enable`=1, no load → `An` sequence 1111,1111,1110×6, then 1111×2,1101×6, and so on; `SSeg`=8'b00000011 during lit cycles; `FrameTick` every 32 cycles.
- `Load` `Value`=16'h12AF, `DPMask`=4'b0100, `LZB`=0 → `Pending`=1 until boundary; next frame shows `SSeg`: digit0 8'b01110001, digit1 8'b00010001, digit2 8'b00100100, digit3 8'b10011111.
- `Load` `Value`=16'h0050, `LZB`=1, `DPMask`=4'b1000 → digit0 "0", digit1 "5", digit2 8'hFF, digit3 8'hFE.
- Two `Load`s in one frame (16'h1111, then 16'h2222) → only 2222 is ever displayed. A `Load` on the boundary cycle → displayed that frame, `Pending` stays 0.
- `Enable`=0 mid-slot for 20 cycles → `An`=1111, `SSeg`=8'hFF, no `FrameTick`. Re-enable → `Idx`/`Cnt` resume.
- `Reset` pulse mid-frame with `Pending`=1 → all outputs at reset values at once; pending discarded; display returns to "0000".
